// File: rtl/truco_pkg.sv
// Shared types for the Truco hand sequencer: FSM states, trick-result codes,
// the stake ladder and its step function, and the default match-ending score.
// No logic state lives here; latency and backpressure do not apply.
package truco_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_WAIT_SECOND,
    S_COMPARE,
    S_RAISE_PEND,
    S_HAND_DONE,
    S_GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_P1   = 2'd1,
    TR_P2   = 2'd2,
    TR_TIE  = 2'd3
  } trick_t;

  localparam logic [3:0] STAKE_1  = 4'd1;
  localparam logic [3:0] STAKE_3  = 4'd3;
  localparam logic [3:0] STAKE_6  = 4'd6;
  localparam logic [3:0] STAKE_9  = 4'd9;
  localparam logic [3:0] STAKE_12 = 4'd12;

  localparam int WIN_SCORE_DEF = 12;

  // One rung up the truco ladder; the top rung is sticky.
  function automatic logic [3:0] next_stake(input logic [3:0] s);
    case (s)
      STAKE_1: next_stake = STAKE_3;
      STAKE_3: next_stake = STAKE_6;
      STAKE_6: next_stake = STAKE_9;
      default: next_stake = STAKE_12;
    endcase
  endfunction

endpackage

// File: rtl/truco_hand_judge.sv
// Hand judge: maps the three trick results to {resolved, no_points, winner}.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: t0..t2 trick results (TR_NONE = not yet played); winner 0 = P1, 1 = P2.
module truco_hand_judge
  import truco_pkg::*;
(
  input  trick_t t0,
  input  trick_t t1,
  input  trick_t t2,
  output logic   resolved,
  output logic   no_points,
  output logic   winner
);

  logic [1:0] w1, w2;
  logic       t0_win, t1_win, t2_win;

  always_comb begin
    w1 = {1'b0, t0 == TR_P1} + {1'b0, t1 == TR_P1} + {1'b0, t2 == TR_P1};
    w2 = {1'b0, t0 == TR_P2} + {1'b0, t1 == TR_P2} + {1'b0, t2 == TR_P2};
    t0_win = (t0 == TR_P1) || (t0 == TR_P2);
    t1_win = (t1 == TR_P1) || (t1 == TR_P2);
    t2_win = (t2 == TR_P1) || (t2 == TR_P2);

    resolved  = 1'b1;
    no_points = 1'b0;
    winner    = 1'b0;
    if (w1 >= 2'd2) begin
      winner = 1'b0;
    end else if (w2 >= 2'd2) begin
      winner = 1'b1;
    end else if (t0 == TR_TIE && t1_win) begin
      winner = (t1 == TR_P2);
    end else if (t0_win && t1 == TR_TIE) begin
      winner = (t0 == TR_P2);
    end else if (t0_win && t2 == TR_TIE) begin
      // Split first two tricks, third tied: first-trick winner takes it.
      winner = (t0 == TR_P2);
    end else if (t0 == TR_TIE && t1 == TR_TIE && t2_win) begin
      winner = (t2 == TR_P2);
    end else if (t0 == TR_TIE && t1 == TR_TIE && t2 == TR_TIE) begin
      no_points = 1'b1;
    end else begin
      resolved = 1'b0;
    end
  end

endmodule

// File: rtl/truco_hand_ctrl.sv
// Truco match sequencer: turns, trick compare, best-of-three hands, raise ladder, score to WIN_SCORE.
// Latency: each accepted pulse acts on the same edge; all outputs registered (visible next cycle).
// Backpressure: none; pulses not valid for the current state/turn are dropped.
// Ports: Clk/Clr clock and async active-low clear; Start/Play1/Play2/Raise/Accept/Fold event
// pulses; P1/P2 offered cards; PS1/PS2/Cmp to the compare datapath; Turn, Stake, Score1/2,
// HandEnd, End, Winner to display logic.
module truco_hand_ctrl
  import truco_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Start,
  input  logic [2:0] P1,
  input  logic [2:0] P2,
  input  logic       Play1,
  input  logic       Play2,
  input  logic       Raise,
  input  logic       Accept,
  input  logic       Fold,
  output logic [2:0] PS1,
  output logic [2:0] PS2,
  output logic       Cmp,
  output logic       Turn,
  output logic [3:0] Stake,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic       HandEnd,
  output logic       End,
  output logic       Winner
);

  localparam logic [4:0] WIN5 = 5'(WIN_SCORE);

  state_t     state, saved_state;
  trick_t     t0, t1, t2;
  trick_t     cur_res, n0, n1, n2;
  logic [1:0] trick_idx;
  logic       starter, leader, saved_turn;
  logic       raiser_vld, raiser;
  logic       award_p2, award_none;
  logic       resolved, no_points, hand_winner;
  logic       turn_play, raise_ok;
  logic [4:0] sum1, sum2, new1, new2;

  // Judge sees the trick table as it will be after the current compare lands.
  always_comb begin
    cur_res = TR_TIE;
    if (PS1 > PS2)      cur_res = TR_P1;
    else if (PS2 > PS1) cur_res = TR_P2;
    n0 = t0;
    n1 = t1;
    n2 = t2;
    case (trick_idx)
      2'd0:    n0 = cur_res;
      2'd1:    n1 = cur_res;
      default: n2 = cur_res;
    endcase
  end

  truco_hand_judge u_judge (
    .t0        (n0),
    .t1        (n1),
    .t2        (n2),
    .resolved  (resolved),
    .no_points (no_points),
    .winner    (hand_winner)
  );

  always_comb begin
    turn_play = Turn ? Play2 : Play1;
    // A player may not re-raise their own accepted raise.
    raise_ok  = Raise && (Stake != STAKE_12) && !(raiser_vld && (raiser == Turn));
    sum1 = {1'b0, Score1} + {1'b0, Stake};
    sum2 = {1'b0, Score2} + {1'b0, Stake};
    new1 = {1'b0, Score1};
    new2 = {1'b0, Score2};
    if (!award_none && !award_p2) new1 = (sum1 >= WIN5) ? WIN5 : sum1;
    if (!award_none &&  award_p2) new2 = (sum2 >= WIN5) ? WIN5 : sum2;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state       <= S_IDLE;
      saved_state <= S_IDLE;
      PS1         <= 3'd0;
      PS2         <= 3'd0;
      Cmp         <= 1'b0;
      Turn        <= 1'b0;
      Stake       <= STAKE_1;
      Score1      <= 4'd0;
      Score2      <= 4'd0;
      HandEnd     <= 1'b0;
      End         <= 1'b0;
      Winner      <= 1'b0;
      t0          <= TR_NONE;
      t1          <= TR_NONE;
      t2          <= TR_NONE;
      trick_idx   <= 2'd0;
      starter     <= 1'b0;
      leader      <= 1'b0;
      saved_turn  <= 1'b0;
      raiser_vld  <= 1'b0;
      raiser      <= 1'b0;
      award_p2    <= 1'b0;
      award_none  <= 1'b0;
    end else begin
      Cmp     <= 1'b0;
      HandEnd <= 1'b0;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (Start) begin
            Score1     <= 4'd0;
            Score2     <= 4'd0;
            End        <= 1'b0;
            Winner     <= 1'b0;
            Stake      <= STAKE_1;
            starter    <= 1'b0;
            Turn       <= 1'b0;
            t0         <= TR_NONE;
            t1         <= TR_NONE;
            t2         <= TR_NONE;
            trick_idx  <= 2'd0;
            raiser_vld <= 1'b0;
            state      <= S_WAIT_FIRST;
          end
        end
        S_WAIT_FIRST, S_WAIT_SECOND: begin
          // Raise outranks a same-cycle Play, which is dropped.
          if (raise_ok) begin
            saved_state <= state;
            saved_turn  <= Turn;
            Turn        <= ~Turn;
            state       <= S_RAISE_PEND;
          end else if (turn_play) begin
            if (Turn) PS2 <= P2;
            else      PS1 <= P1;
            if (state == S_WAIT_FIRST) begin
              leader <= Turn;
              Turn   <= ~Turn;
              state  <= S_WAIT_SECOND;
            end else begin
              Cmp    <= 1'b1;
              state  <= S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          t0 <= n0;
          t1 <= n1;
          t2 <= n2;
          if (resolved) begin
            award_none <= no_points;
            award_p2   <= hand_winner;
            state      <= S_HAND_DONE;
          end else begin
            trick_idx <= trick_idx + 2'd1;
            // Tie: the leader of the tied trick leads again.
            Turn      <= (cur_res == TR_TIE) ? leader : (cur_res == TR_P2);
            state     <= S_WAIT_FIRST;
          end
        end
        S_RAISE_PEND: begin
          if (Fold) begin
            award_none <= 1'b0;
            award_p2   <= saved_turn;
            state      <= S_HAND_DONE;
          end else if (Accept) begin
            Stake      <= next_stake(Stake);
            raiser_vld <= 1'b1;
            raiser     <= saved_turn;
            Turn       <= saved_turn;
            state      <= saved_state;
          end
        end
        S_HAND_DONE: begin
          Score1  <= new1[3:0];
          Score2  <= new2[3:0];
          HandEnd <= 1'b1;
          if (new1 >= WIN5 || new2 >= WIN5) begin
            End    <= 1'b1;
            Winner <= (new2 >= WIN5);
            state  <= S_GAME_OVER;
          end else begin
            t0         <= TR_NONE;
            t1         <= TR_NONE;
            t2         <= TR_NONE;
            trick_idx  <= 2'd0;
            Stake      <= STAKE_1;
            raiser_vld <= 1'b0;
            starter    <= ~starter;
            Turn       <= ~starter;
            state      <= S_WAIT_FIRST;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truco_hand_ctrl.sv
// Self-checking bench for truco_hand_ctrl: scoreboard queues for compare and hand-end events.
// Latency/backpressure: inputs driven at negedge, outputs sampled at negedge.
// Ports: none (top-level bench).
module tb_truco_hand_ctrl;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] P1 = 3'd0;
  logic [2:0] P2 = 3'd0;
  logic       Play1 = 1'b0, Play2 = 1'b0, Raise = 1'b0, Accept = 1'b0, Fold = 1'b0;
  logic [2:0] PS1, PS2;
  logic       Cmp, Turn, HandEnd, End, Winner;
  logic [3:0] Stake, Score1, Score2;

  int checks = 0;
  int errors = 0;
  logic [5:0] cmp_q[$];
  logic [7:0] hand_q[$];
  logic [5:0] mon_c;
  logic [7:0] mon_h;

  always #5 Clk = ~Clk;

  truco_hand_ctrl #(.WIN_SCORE(12)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .P1(P1), .P2(P2),
    .Play1(Play1), .Play2(Play2), .Raise(Raise), .Accept(Accept), .Fold(Fold),
    .PS1(PS1), .PS2(PS2), .Cmp(Cmp), .Turn(Turn), .Stake(Stake),
    .Score1(Score1), .Score2(Score2), .HandEnd(HandEnd), .End(End), .Winner(Winner)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard side: every Cmp and HandEnd must match a queued expectation.
  always @(negedge Clk) begin
    if (Clr) begin
      if (Cmp) begin
        if (cmp_q.size() == 0) check("cmp_unexpected", 1, 0);
        else begin
          mon_c = cmp_q.pop_front();
          check("cmp_ps1", PS1, mon_c[5:3]);
          check("cmp_ps2", PS2, mon_c[2:0]);
        end
      end
      if (HandEnd) begin
        if (hand_q.size() == 0) check("handend_unexpected", 1, 0);
        else begin
          mon_h = hand_q.pop_front();
          check("score1", Score1, mon_h[7:4]);
          check("score2", Score2, mon_h[3:0]);
        end
      end
    end
  end

  task automatic pulse(input bit st, input bit p1, input bit p2, input bit rs,
                       input bit ac, input bit fd, input logic [2:0] c1, input logic [2:0] c2);
    @(negedge Clk);
    Start = st; Play1 = p1; Play2 = p2; Raise = rs; Accept = ac; Fold = fd; P1 = c1; P2 = c2;
    @(negedge Clk);
    Start = 0; Play1 = 0; Play2 = 0; Raise = 0; Accept = 0; Fold = 0;
  endtask

  task automatic play(input bit who, input logic [2:0] c);
    if (who) pulse(0, 0, 1, 0, 0, 0, 3'd0, c);
    else     pulse(0, 1, 0, 0, 0, 0, c, 3'd0);
  endtask

  task automatic raise_();  pulse(0, 0, 0, 1, 0, 0, 3'd0, 3'd0); endtask
  task automatic accept_(); pulse(0, 0, 0, 0, 1, 0, 3'd0, 3'd0); endtask
  task automatic fold_();   pulse(0, 0, 0, 0, 0, 1, 3'd0, 3'd0); endtask

  // c1 is P1's card, c2 is P2's card; lead picks the order of play.
  task automatic trick(input bit lead, input logic [2:0] c1, input logic [2:0] c2);
    cmp_q.push_back({c1, c2});
    if (lead) begin play(1, c2); play(0, c1); end
    else      begin play(0, c1); play(1, c2); end
    @(negedge Clk);
  endtask

  task automatic end_hand(input logic [3:0] s1, input logic [3:0] s2);
    bit seen;
    seen = 0;
    hand_q.push_back({s1, s2});
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      if (HandEnd) seen = 1;
    end
    check("handend_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_stake", Stake, 1);
    check("rst_turn", Turn, 0);
    check("rst_score1", Score1, 0);
    check("rst_end", End, 0);
    check("rst_cmp", Cmp, 0);
    @(negedge Clk);
    Clr = 1;
    pulse(1, 0, 0, 0, 0, 0, 3'd0, 3'd0);

    // Hand 1: P1 starts and wins two straight tricks.
    play(1, 3'd7);
    check("nonturn_turn", Turn, 0);
    check("nonturn_ps2", PS2, 0);
    trick(0, 3'd5, 3'd3);
    check("h1_t1_turn", Turn, 0);
    trick(0, 3'd6, 3'd2);
    end_hand(4'd1, 4'd0);
    check("h1_next_turn", Turn, 1);

    // Hand 2: P2 starts, first trick tied, P2 keeps the lead and wins trick 2.
    trick(1, 3'd4, 3'd4);
    check("tie_lead", Turn, 1);
    trick(1, 3'd1, 3'd7);
    end_hand(4'd1, 4'd1);
    check("h2_next_turn", Turn, 0);

    // Hand 3: raise ladder, ignored self re-raise, fold at stake 9.
    raise_();
    check("r1_answer_turn", Turn, 1);
    accept_();
    check("r1_stake", Stake, 3);
    check("r1_resume_turn", Turn, 0);
    play(0, 3'd2);
    raise_();
    accept_();
    check("r2_stake", Stake, 6);
    cmp_q.push_back({3'd2, 3'd3});
    play(1, 3'd3);
    @(negedge Clk);
    check("h3_t1_turn", Turn, 1);
    raise_();
    check("self_reraise_turn", Turn, 1);
    check("self_reraise_stake", Stake, 6);
    play(1, 3'd1);
    raise_();
    check("r3_answer_turn", Turn, 1);
    accept_();
    check("r3_stake", Stake, 9);
    cmp_q.push_back({3'd5, 3'd1});
    play(0, 3'd5);
    @(negedge Clk);
    check("h3_t2_turn", Turn, 0);
    play(0, 3'd4);
    raise_();
    check("r4_answer_turn", Turn, 0);
    fold_();
    end_hand(4'd1, 4'd10);
    check("h3_stake_reset", Stake, 1);
    check("h3_next_turn", Turn, 1);

    // Hand 4: Raise beats a same-cycle Play; Fold beats a same-cycle Accept.
    pulse(0, 0, 1, 1, 0, 0, 3'd0, 3'd6);
    check("raise_play_ps2", PS2, 1);
    check("raise_play_turn", Turn, 0);
    pulse(0, 0, 0, 0, 1, 1, 3'd0, 3'd0);
    end_hand(4'd1, 4'd11);
    check("h4_stake", Stake, 1);

    // Hand 5: P2 wins at stake 3 from 11, score saturates at 12.
    raise_();
    accept_();
    check("h5_stake", Stake, 3);
    trick(0, 3'd0, 3'd7);
    check("h5_t1_turn", Turn, 1);
    trick(1, 3'd2, 3'd6);
    end_hand(4'd1, 4'd12);
    check("go_end", End, 1);
    check("go_winner", Winner, 1);
    play(0, 3'd5);
    check("go_ps1_hold", PS1, 2);
    check("go_score2_hold", Score2, 12);

    pulse(1, 0, 0, 0, 0, 0, 3'd0, 3'd0);
    check("restart_s1", Score1, 0);
    check("restart_s2", Score2, 0);
    check("restart_end", End, 0);
    check("restart_turn", Turn, 0);

    // Asynchronous clear while a raise is pending.
    raise_();
    accept_();
    play(0, 3'd3);
    raise_();
    check("pend_turn", Turn, 0);
    check("pend_stake", Stake, 3);
    @(negedge Clk);
    #2 Clr = 0;
    #1;
    check("clr_stake", Stake, 1);
    check("clr_ps1", PS1, 0);
    check("clr_score2", Score2, 0);
    check("clr_end", End, 0);
    @(negedge Clk);
    Clr = 1;
    play(0, 3'd5);
    check("idle_play_ps1", PS1, 0);
    check("idle_play_turn", Turn, 0);

    check("cmp_q_empty", cmp_q.size(), 0);
    check("hand_q_empty", hand_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
